// File: rtl/frame_buffer_reader.sv
// VGA timing generator that reads a 320x240 RGB565 frame buffer and shows it 2x upscaled.
// Counter state at cycle t reaches every output at cycle t+3, matching a 1-cycle synchronous RAM.
module frame_buffer_reader #(
   parameter int H_VISIBLE = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33
) (
   input  logic        pclk,
   input  logic        reset,
   output logic        oe,
   output logic [16:0] rAddr,
   input  logic [15:0] rData,
   output logic        h_sync,
   output logic        v_sync,
   output logic        de,
   output logic [3:0]  red,
   output logic [3:0]  green,
   output logic [3:0]  blue,
   output logic [9:0]  x_pixel,
   output logic [9:0]  y_pixel,
   output logic        frame_start
);

   localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
   localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
   localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
   localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

   logic [9:0]  h_cnt;
   logic [9:0]  v_cnt;
   logic        visible;
   logic        hs_n;
   logic        vs_n;
   logic [16:0] addr;

   logic        vis_1_r;
   logic        hs_1_r;
   logic        vs_1_r;
   logic [9:0]  h_1_r;
   logic [9:0]  v_1_r;

   logic        vis_2_r;
   logic        hs_2_r;
   logic        vs_2_r;
   logic [9:0]  h_2_r;
   logic [9:0]  v_2_r;

   logic        unused_data;
   assign unused_data = ^{rData[11], rData[5], rData[0]};

   // Horizontal and vertical raster counters; v advances only on the h wrap.
   always_ff @(posedge pclk) begin
      if (reset) begin
         h_cnt <= 10'd0;
         v_cnt <= 10'd0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= 10'd0;
         if (v_cnt == V_LAST) begin
            v_cnt <= 10'd0;
         end else begin
            v_cnt <= v_cnt + 10'd1;
         end
      end else begin
         h_cnt <= h_cnt + 10'd1;
      end
   end

   // Stage-0 decode; the address is y2*320 + x2 built as y2*256 + y2*64 + x2.
   always_comb begin
      visible = (h_cnt < H_VIS) && (v_cnt < V_VIS);
      hs_n    = !((h_cnt >= HS_START) && (h_cnt <= HS_END));
      vs_n    = !((v_cnt >= VS_START) && (v_cnt <= VS_END));
      addr    = ({8'd0, v_cnt[9:1]} << 8) + ({8'd0, v_cnt[9:1]} << 6) + {8'd0, h_cnt[9:1]};
   end

   // Stage 1: issue the read; the address holds through blanking.
   always_ff @(posedge pclk) begin
      if (reset) begin
         oe      <= 1'b0;
         rAddr   <= 17'd0;
         vis_1_r <= 1'b0;
         hs_1_r  <= 1'b1;
         vs_1_r  <= 1'b1;
         h_1_r   <= 10'd0;
         v_1_r   <= 10'd0;
      end else begin
         oe      <= visible;
         if (visible) begin
            rAddr <= addr;
         end else begin
            rAddr <= rAddr;
         end
         vis_1_r <= visible;
         hs_1_r  <= hs_n;
         vs_1_r  <= vs_n;
         h_1_r   <= h_cnt;
         v_1_r   <= v_cnt;
      end
   end

   // Stage 2: timing delayed one more cycle so it lines up with rData.
   always_ff @(posedge pclk) begin
      if (reset) begin
         vis_2_r <= 1'b0;
         hs_2_r  <= 1'b1;
         vs_2_r  <= 1'b1;
         h_2_r   <= 10'd0;
         v_2_r   <= 10'd0;
      end else begin
         vis_2_r <= vis_1_r;
         hs_2_r  <= hs_1_r;
         vs_2_r  <= vs_1_r;
         h_2_r   <= h_1_r;
         v_2_r   <= v_1_r;
      end
   end

   // Stage 3: output register; colour is forced to black outside the visible area.
   always_ff @(posedge pclk) begin
      if (reset) begin
         h_sync      <= 1'b1;
         v_sync      <= 1'b1;
         de          <= 1'b0;
         red         <= 4'd0;
         green       <= 4'd0;
         blue        <= 4'd0;
         x_pixel     <= 10'd0;
         y_pixel     <= 10'd0;
         frame_start <= 1'b0;
      end else begin
         h_sync  <= hs_2_r;
         v_sync  <= vs_2_r;
         de      <= vis_2_r;
         x_pixel <= h_2_r;
         y_pixel <= v_2_r;
         if (vis_2_r) begin
            red   <= rData[15:12];
            green <= rData[10:7];
            blue  <= rData[4:1];
         end else begin
            red   <= 4'd0;
            green <= 4'd0;
            blue  <= 4'd0;
         end
         frame_start <= vis_2_r && (h_2_r == 10'd0) && (v_2_r == 10'd0);
      end
   end

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Randomised bench for frame_buffer_reader on a reduced raster, with a RAM model and a
// reference model that derives every output from the raster position index.
module tb_frame_buffer_reader;

   localparam int HV = 16, HFP = 2, HSY = 3, HBP = 3;
   localparam int VV = 8, VFP = 1, VSY = 2, VBP = 1;
   localparam int HT = HV + HFP + HSY + HBP;
   localparam int VT = VV + VFP + VSY + VBP;

   logic        pclk = 1'b0;
   logic        reset;
   logic        oe;
   logic [16:0] rAddr;
   logic [15:0] rData;
   logic        h_sync, v_sync, de, frame_start;
   logic [3:0]  red, green, blue;
   logic [9:0]  x_pixel, y_pixel;

   logic [15:0] mem [0:76799];
   int n_cmp = 0;
   int n_err = 0;
   int t = 0;
   int exp_addr = 0;

   frame_buffer_reader #(
      .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
   ) dut (
      .pclk(pclk), .reset(reset), .oe(oe), .rAddr(rAddr), .rData(rData),
      .h_sync(h_sync), .v_sync(v_sync), .de(de),
      .red(red), .green(green), .blue(blue),
      .x_pixel(x_pixel), .y_pixel(y_pixel), .frame_start(frame_start)
   );

   always #5 pclk = ~pclk;

   // 1-cycle synchronous RAM; returns garbage whenever no read is issued
   always @(posedge pclk) begin
      if (oe && rAddr < 17'd76800) rData <= mem[rAddr];
      else rData <= 16'($urandom);
   end

   function automatic int hpos(int idx); return idx % HT; endfunction
   function automatic int vpos(int idx); return (idx / HT) % VT; endfunction
   function automatic bit vis_at(int idx); return hpos(idx) < HV && vpos(idx) < VV; endfunction
   function automatic int addr_at(int idx); return (vpos(idx) / 2) * 320 + hpos(idx) / 2; endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at t=%0d: got %0h, expected %0h", tag, t, obs, exp);
      end
   endtask

   task automatic check_all();
      int idx;
      logic [15:0] w;
      logic [3:0] er, eg, eb;
      check_eq("oe", 32'(oe), (t >= 1) ? 32'(vis_at(t - 1)) : 32'd0);
      check_eq("rAddr", 32'(rAddr), 32'(exp_addr));
      if (t >= 3) begin
         idx = t - 3;
         er = 4'd0; eg = 4'd0; eb = 4'd0;
         if (vis_at(idx)) begin
            w  = mem[addr_at(idx)];
            er = w[15:12]; eg = w[10:7]; eb = w[4:1];
         end
         check_eq("h_sync", 32'(h_sync),
                  32'(!(hpos(idx) >= HV + HFP && hpos(idx) < HV + HFP + HSY)));
         check_eq("v_sync", 32'(v_sync),
                  32'(!(vpos(idx) >= VV + VFP && vpos(idx) < VV + VFP + VSY)));
         check_eq("de", 32'(de), 32'(vis_at(idx)));
         check_eq("rgb", 32'({red, green, blue}), 32'({er, eg, eb}));
         check_eq("x_pixel", 32'(x_pixel), 32'(hpos(idx)));
         check_eq("y_pixel", 32'(y_pixel), 32'(vpos(idx)));
         check_eq("frame_start", 32'(frame_start), 32'(hpos(idx) == 0 && vpos(idx) == 0));
      end else begin
         check_eq("rst_out", 32'({h_sync, v_sync, de, red, green, blue, frame_start}),
                  32'({1'b1, 1'b1, 1'b0, 12'd0, 1'b0}));
         check_eq("rst_xy", 32'({x_pixel, y_pixel}), 32'd0);
      end
   endtask

   // one clock: advance the model at the edge, check outputs on the falling edge
   task automatic step();
      @(posedge pclk);
      if (reset) begin
         t = 0;
         exp_addr = 0;
      end else begin
         if (vis_at(t)) exp_addr = addr_at(t);
         t = t + 1;
      end
      @(negedge pclk);
      check_all();
   endtask

   initial begin
      reset = 1'b1;
      for (int i = 0; i < 76800; i++) mem[i] = 16'($urandom);
      mem[321] = 16'hF81F;
      repeat (3) step();
      reset = 1'b0;
      repeat (3 * HT * VT + 20) step();
      for (int k = 0; k < 8; k++) begin
         repeat ($urandom_range(5, 2 * HT * VT)) step();
         reset = 1'b1;
         repeat ($urandom_range(1, 3)) step();
         reset = 1'b0;
      end
      repeat (2 * HT * VT + 10) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/frame_buffer_reader.md
FRAME_BUFFER_READER -- requirements
Module: frame_buffer_reader

Interface
REQ-001 SHALL have parameter H_VISIBLE, default 640: active pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48: horizontal porch and sync widths in pclk cycles.
REQ-003 SHALL have parameter V_VISIBLE, default 480: active lines per frame.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33: vertical porch and sync widths in lines.
REQ-005 SHALL have port pclk, input, 1: the single clock, pixel rate (25 MHz nominal).
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port oe, output, 1: frame-buffer read enable.
REQ-008 SHALL have port rAddr, output, 17: frame-buffer read address, 320x240 RGB565 words.
REQ-009 SHALL have port rData, input, 16: RGB565 read data, valid the cycle after rAddr/oe.
REQ-010 SHALL have ports h_sync and v_sync, outputs, 1 each: active-low syncs.
REQ-011 SHALL have port de, output, 1: display-enable (visible pixel).
REQ-012 SHALL have ports red, green, blue, outputs, 4 each: VGA color.
REQ-013 SHALL have ports x_pixel and y_pixel, outputs, 10 each: coordinate of the pixel on the outputs.
REQ-014 SHALL have port frame_start, output, 1: one-cycle pulse with pixel (0,0) on the outputs.

Function
REQ-015 SHALL keep counter h_cnt 0..H_TOTAL-1 (H_TOTAL = sum of horizontal parameters = 800), +1 per cycle, 799 wraps to 0.
REQ-016 SHALL keep counter v_cnt 0..V_TOTAL-1 (525); +1 only on the h_cnt wrap cycle; 524 wraps to 0 on the same cycle as the h_cnt wrap.
REQ-017 Stage-0 decode: visible = h_cnt<640 && v_cnt<480; hs_n low when 656<=h_cnt<=751; vs_n low when 490<=v_cnt<=491.
REQ-018 Stage 1 (registered): oe = visible; rAddr = (v_cnt>>1)*320 + (h_cnt>>1) when visible, otherwise rAddr holds its previous value.
REQ-019 Address SHALL be computed with shifts and adds only (y2<<8 + y2<<6 + x2); maximum 76799; no multiplier.
REQ-020 The 2x upscale SHALL present each stored pixel on two consecutive columns of two consecutive lines.
REQ-021 Stage 2 SHALL delay hs_n, vs_n, visible, h_cnt, and v_cnt one further cycle, aligned with rData.
REQ-022 Stage 3 (output register) SHALL drive red=rData[15:12], green=rData[10:7], blue=rData[4:1] when delayed visible, otherwise 0.
REQ-023 h_sync, v_sync, de, x_pixel, y_pixel SHALL be the stage-2 values, registered into stage 3.
REQ-024 Total latency: counter state at cycle t appears on all outputs at cycle t+3; syncs, de, and color SHALL remain mutually aligned.
REQ-025 frame_start SHALL be 1 exactly when outputs show h=0,v=0: one cycle per 420000 cycles.
REQ-026 Outside the visible area, rData SHALL be ignored and no read SHALL be issued (oe=0).

Reset
REQ-027 While reset: h_cnt=0, v_cnt=0, all pipeline stages flushed; oe=0, rAddr=0, h_sync=1, v_sync=1, de=0, red/green/blue=0, x_pixel=0, y_pixel=0, frame_start=0.
REQ-028 On the first cycle after reset deasserts, the counter state SHALL be (0,0); first oe=1 occurs 1 cycle later; de=1 and frame_start=1 occur 3 cycles later.
REQ-029 Reset asserted mid-frame SHALL restart timing at (0,0) with no partial-line output after release.

Verification
REQ-030 Release reset; model a 1-cycle synchronous RAM -> frame_start high at cycle 3, de high for 640 cycles, low for 160, per line.
REQ-031 Count a full frame -> h_sync low 96 cycles starting 656 cycles after the de rise; v_sync low for lines 490-491; frame period 420000 cycles.
REQ-032 RAM word at address 321 = 16'hF81F; others 0 -> color F/0/F only at x=2,3 and y=2,3; rAddr=321 issued with oe=1.
REQ-033 Check the last pixel (639,479) -> rAddr=76799; next cycle oe=0; rAddr holds 76799 through blanking.
REQ-034 Drive rData=16'hFFFF constantly -> red/green/blue=0 whenever de=0; F/F/F whenever de=1.
REQ-035 Assert reset for 1 cycle at (300,200) -> next output state matches the REQ-027 reset values; de rises exactly 3 cycles after release with x_pixel=0, y_pixel=0.
